// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM state and owner encodings.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    // Latency and starvation counters both cover the 1..15 parameter range.
    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_C)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and load/store,
// returning data with a one-cycle ready pulse and driving the pipeline stall lines.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ready,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [3:0]  i_dm_wmask,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_ready,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_wmask,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall_if,
    output logic        o_stall_mem
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    arb_state_t       r_state, w_state_next;
    arb_owner_t       r_owner;
    logic             r_killed;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [31:0]      r_addr, r_wdata, r_if_rdata, r_dm_rdata;
    logic             r_we;
    logic [3:0]       r_wmask;

    logic w_idle, w_start, w_grant_dm, w_at_max, w_inc, w_clr;

    // A waiting fetch overrides data priority once the starvation budget is spent.
    assign w_idle     = (r_state == ARB_IDLE);
    assign w_grant_dm = i_dm_req && !(i_if_req && w_at_max);
    assign w_start    = w_idle && (i_if_req || i_dm_req);
    assign w_inc      = w_idle && w_grant_dm && i_if_req;
    assign w_clr      = w_idle && !(w_grant_dm && i_if_req);

    arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_owner    <= OWN_IF;
            r_killed   <= 1'b0;
            r_lat_cnt  <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_wmask    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ARB_IDLE: begin
                    r_killed <= 1'b0;
                    if (w_start) begin
                        r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
                        r_addr  <= w_grant_dm ? i_dm_addr : i_if_addr;
                        r_we    <= w_grant_dm && i_dm_we;
                        r_wmask <= w_grant_dm ? i_dm_wmask : 4'b0000;
                        r_wdata <= w_grant_dm ? i_dm_wdata : 32'd0;
                    end
                end
                ARB_ISSUE: r_lat_cnt <= LAT_C;
                ARB_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 1'b1;
                    if (r_lat_cnt == CNT_W'(1)) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= i_mem_rdata;
                        end else if (!r_we) begin
                            r_dm_rdata <= i_mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
            // The fetch read still runs to completion; only its ready pulse is suppressed.
            if (!w_idle && (r_owner == OWN_IF) && i_if_flush) begin
                r_killed <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_mem_en     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_wmask  = 4'b0000;
        o_mem_addr   = 32'd0;
        o_mem_wdata  = 32'd0;
        o_if_ready   = 1'b0;
        o_dm_ready   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_start) begin
                    w_state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                w_state_next = ARB_WAIT;
                o_mem_en     = 1'b1;
                o_mem_addr   = r_addr;
                if ((r_owner == OWN_DM) && r_we) begin
                    o_mem_we    = 1'b1;
                    o_mem_wmask = r_wmask;
                    o_mem_wdata = r_wdata;
                end
            end
            ARB_WAIT: begin
                if (r_lat_cnt == CNT_W'(1)) begin
                    w_state_next = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_state_next = ARB_IDLE;
                o_if_ready   = (r_owner == OWN_IF) && !r_killed && !i_if_flush;
                o_dm_ready   = (r_owner == OWN_DM);
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_stall_if  = i_if_req && !o_if_ready;
    assign o_stall_mem = i_dm_req && !o_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam int NCYC = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst1;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_wmask;

    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem;
    logic [3:0]  mem_wmask;

    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_ready1, dm_ready1, mem_en1, mem_we1, stall_if1, stall_mem1;
    logic [3:0]  mem_wmask1;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_rdata(if_rdata), .o_if_ready(if_ready),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_wmask(dm_wmask),
        .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_rdata(dm_rdata), .o_dm_ready(dm_ready),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_wmask(mem_wmask),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_stall_if(stall_if), .o_stall_mem(stall_mem)
    );

    // Minimum-latency instance, only released from reset for the single-load check.
    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
        .clk(clk), .rst(rst1),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_rdata(if_rdata1), .o_if_ready(if_ready1),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_wmask(dm_wmask),
        .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_rdata(dm_rdata1), .o_dm_ready(dm_ready1),
        .o_mem_en(mem_en1), .o_mem_we(mem_we1), .o_mem_wmask(mem_wmask1),
        .o_mem_addr(mem_addr1), .o_mem_wdata(mem_wdata1), .i_mem_rdata(mem_rdata1),
        .o_stall_if(stall_if1), .o_stall_mem(stall_mem1)
    );

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 64) return 32'hDEADBEEF;
        return {b, ~b, 8'(i * 3), 8'hA5};
    endfunction

    function automatic logic [31:0] rand_addr();
        return $urandom & 32'h0000_0FFC;
    endfunction

    // Memory device: data appears exactly LAT cycles after mem_en, garbage otherwise.
    logic [31:0] mem_arr [256];
    logic        mem_loaded = 1'b0;
    logic [31:0] pipe0, pipe1, pipe_b;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        pipe0  <= mem_en  ? mem_arr[mem_addr[9:2]]  : $urandom;
        pipe1  <= pipe0;
        pipe_b <= mem_en1 ? mem_arr[mem_addr1[9:2]] : $urandom;
    end
    assign mem_rdata  = pipe1;
    assign mem_rdata1 = pipe_b;

    logic [31:0] ref_mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic ref_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int ev[6];
        int nev;
        int busy, m_t, m_next, streak, ntxn;
        logic m_dm, m_we, m_killed, issue, resp, e_ifr, e_dmr, prev_ifr, prev_dmr;
        logic [31:0] m_addr, m_wdata, m_rd, e_if_rdata, e_dm_rdata;
        logic [3:0]  m_wmask;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst = 1; rst1 = 1; if_req = 0; if_flush = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_wmask = 0; dm_addr = 0; dm_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_if_ready", if_ready, 0);
        check_val("rst_dm_ready", dm_ready, 0);
        check_val("rst_if_rdata", if_rdata, 0);
        check_val("rst_dm_rdata", dm_rdata, 0);

        // Single load, both latencies.
        rst = 0; rst1 = 0;
        dm_req = 1; dm_addr = 32'h100;
        #1;
        check_val("ld_stall_mem0", stall_mem, 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_val("ld_mem_en", mem_en, c == 1);
            if (c == 1) check_val("ld_mem_addr", mem_addr, 32'h100);
            check_val("ld_dm_ready", dm_ready, c == 4);
            check_val("ld_stall_mem", stall_mem, c < 4);
            check_val("ld1_dm_ready", dm_ready1, c == 3);
            if (c == 3) check_val("ld1_dm_rdata", dm_rdata1, 32'hDEADBEEF);
            if (c == 4) check_val("ld_dm_rdata", dm_rdata, 32'hDEADBEEF);
        end
        $display("txn load addr=00000100 data=%08h", dm_rdata);
        dm_req = 0; rst1 = 1;

        // Store: one write issue, load data register untouched.
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_wmask = 4'b0011; dm_wdata = 32'h1234ABCD; dm_addr = 32'h40;
        ref_store(dm_addr, dm_wmask, dm_wdata);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_val("st_mem_en", mem_en, c == 1);
            check_val("st_mem_we", mem_we, c == 1);
            if (c == 1) begin
                check_val("st_mem_wmask", mem_wmask, 4'b0011);
                check_val("st_mem_addr", mem_addr, 32'h40);
                check_val("st_mem_wdata", mem_wdata, 32'h1234ABCD);
            end
            check_val("st_dm_ready", dm_ready, c == 4);
            if (c == 4) check_val("st_dm_rdata", dm_rdata, 32'hDEADBEEF);
        end
        $display("txn store addr=00000040 data=1234abcd mask=3");
        dm_req = 0; dm_we = 0; dm_wmask = 0;

        // Reset in the middle of WAIT, then a clean fetch.
        @(negedge clk);
        if_req = 1; if_addr = 32'h8;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        check_val("rstw_mem_en", mem_en, 0);
        check_val("rstw_if_ready", if_ready, 0);
        check_val("rstw_if_rdata", if_rdata, 0);
        check_val("rstw_dm_rdata", dm_rdata, 0);
        @(negedge clk);
        rst = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_val("rstw_if_ready_after", if_ready, c == 4);
            if (c == 4) check_val("rstw_if_rdata_after", if_rdata, ref_mem[2]);
        end
        $display("txn fetch addr=00000008 data=%08h", if_rdata);
        if_req = 0;

        // Flush during WAIT: no ready for the first fetch, the held request refetches.
        @(negedge clk);
        if_req = 1; if_addr = 32'h8;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check_val("fl_mem_en", mem_en, (c == 1) || (c == 6));
            check_val("fl_if_ready", if_ready, c == 9);
            check_val("fl_stall_if", stall_if, c < 9);
            if (c == 9) check_val("fl_if_rdata", if_rdata, ref_mem[2]);
            if_flush = (c == 2);
        end
        $display("txn fetch(after flush) addr=00000008 data=%08h", if_rdata);
        if_req = 0;

        // Contention: fetch waits for exactly STARVE_MAX data grants.
        @(negedge clk);
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_addr = 32'h20;
        nev = 0;
        for (int c = 0; c < 60 && nev < 6; c++) begin
            @(negedge clk);
            if (dm_ready) begin ev[nev] = 1; nev++; end
            if (if_ready) begin ev[nev] = 0; nev++; if_req = 0; end
        end
        check_val("ct_events", nev, 6);
        for (int i = 0; i < nev; i++) check_val("ct_grant_order", ev[i], (i == 4) ? 0 : 1);
        $display("txn contention %0d grants, IF position 5", nev);
        dm_req = 0; if_req = 0;

        // Randomized traffic against the transaction model.
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        busy = 0; m_next = 0; streak = 0; ntxn = 0; m_t = 0;
        m_dm = 0; m_we = 0; m_killed = 0; m_addr = 0; m_wdata = 0; m_wmask = 0; m_rd = 0;
        e_if_rdata = 0; e_dm_rdata = 0; prev_ifr = 0; prev_dmr = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (c > 0) @(negedge clk);
            if (if_req) begin
                if (prev_ifr) begin
                    if_req = ($urandom_range(0, 3) == 0);
                    if_addr = rand_addr();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = rand_addr();
            end
            if_flush = if_req && ($urandom_range(0, 7) == 0);
            if (if_flush) if_addr = rand_addr();
            if ((dm_req && prev_dmr && $urandom_range(0, 2) == 0) || (!dm_req && $urandom_range(0, 1) == 0)) begin
                dm_req = 1; dm_we = $urandom_range(0, 1); dm_wmask = 4'($urandom);
                dm_addr = rand_addr(); dm_wdata = $urandom;
            end else if (dm_req && prev_dmr) begin
                dm_req = 0;
            end
            #1;
            issue = busy && (c == m_t + 1);
            resp  = busy && (c == m_t + LAT + 2);
            if (busy && !m_dm && if_flush && c > m_t) m_killed = 1;
            e_ifr = resp && !m_dm && !m_killed;
            e_dmr = resp && m_dm;
            check_val("r_mem_en", mem_en, issue);
            check_val("r_mem_we", mem_we, issue && m_dm && m_we);
            if (issue) check_val("r_mem_addr", mem_addr, m_addr);
            if (issue && m_dm && m_we) begin
                check_val("r_mem_wmask", mem_wmask, m_wmask);
                check_val("r_mem_wdata", mem_wdata, m_wdata);
            end
            check_val("r_if_ready", if_ready, e_ifr);
            check_val("r_dm_ready", dm_ready, e_dmr);
            check_val("r_stall_if", stall_if, if_req && !e_ifr);
            check_val("r_stall_mem", stall_mem, dm_req && !e_dmr);
            if (resp) begin
                if (!m_dm) begin
                    e_if_rdata = m_rd;
                    check_val("r_if_rdata", if_rdata, e_if_rdata);
                end else begin
                    if (!m_we) e_dm_rdata = m_rd;
                    check_val("r_dm_rdata", dm_rdata, e_dm_rdata);
                end
                $display("txn %0d %s %s addr=%08h data=%08h%s", ntxn, m_dm ? "DM" : "IF",
                         (m_dm && m_we) ? "st" : "ld", m_addr, (m_dm && m_we) ? m_wdata : m_rd,
                         (!m_dm && m_killed) ? " flushed" : "");
                ntxn++;
                busy = 0;
            end
            if (!busy && c >= m_next) begin
                if (!if_req) streak = 0;
                if (dm_req && !(if_req && streak == SMAX)) begin
                    busy = 1; m_dm = 1; m_we = dm_we; m_addr = dm_addr;
                    m_wmask = dm_wmask; m_wdata = dm_wdata;
                    if (if_req && streak < SMAX) streak++;
                end else if (if_req) begin
                    busy = 1; m_dm = 0; m_we = 0; m_addr = if_addr;
                    streak = 0;
                end
                if (busy) begin
                    m_t = c; m_next = c + LAT + 3; m_killed = 0;
                    m_rd = ref_mem[m_addr[9:2]];
                    if (m_dm && m_we) ref_store(m_addr, m_wmask, m_wdata);
                end
            end
            prev_ifr = e_ifr;
            prev_dmr = e_dmr;
        end
        check_val("r_txn_progress", (ntxn > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
